// File: rtl/imu_euler_sampler_if.sv
// Byte-level burst bus between the Euler sampler (master) and the IMU bus engine (slave).
interface imu_euler_sampler_if;
  logic       o_Burst_Req;
  logic [7:0] o_Burst_Addr;
  logic [2:0] o_Burst_Len;
  logic       i_Burst_Ack;
  logic       i_Byte_Valid;
  logic [7:0] i_Byte_Data;
  logic       i_Bus_Err;

  modport master (
    output o_Burst_Req, o_Burst_Addr, o_Burst_Len,
    input  i_Burst_Ack, i_Byte_Valid, i_Byte_Data, i_Bus_Err
  );

  modport slave (
    input  o_Burst_Req, o_Burst_Addr, o_Burst_Len,
    output i_Burst_Ack, i_Byte_Valid, i_Byte_Data, i_Bus_Err
  );
endinterface

// File: rtl/imu_euler_sampler.sv
// Periodic six-byte Euler burst reader with commit pulse, staleness and overrun tracking.
// Optional build macro IMU_ANGLE_CLAMP_EN saturates roll to +/-180 deg and pitch to +/-90 deg.
module imu_euler_sampler #(
  parameter int         SAMPLE_PERIOD  = 500000,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] BASE_ADDR      = 8'h1A,
  parameter int         STALE_LIMIT    = 3
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  imu_euler_sampler_if.master        io_Bus,
  output logic [15:0]                o_Heading_Raw,
  output logic [15:0]                o_Roll_Raw,
  output logic [15:0]                o_Pitch_Raw,
  output logic                       o_Valid,
  output logic                       o_Stale,
  output logic                       o_Overrun,
  output logic                       o_Busy
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = $clog2(STALE_LIMIT + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX     = FW'(STALE_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_COMMIT, S_ERR} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_period;
  logic [TW-1:0]   r_timeout;
  logic [FW-1:0]   r_fail;
  logic [2:0]      r_idx;
  logic            r_burst_req;
  logic [7:0]      r_shadow [0:5];

  logic            w_trigger;
  logic [FW-1:0]   w_fail_inc;
  logic [15:0]     w_heading;
  logic [15:0]     w_roll;
  logic [15:0]     w_pitch;
  logic [15:0]     w_roll_out;
  logic [15:0]     w_pitch_out;

  assign io_Bus.o_Burst_Req  = r_burst_req;
  assign io_Bus.o_Burst_Addr = BASE_ADDR;
  assign io_Bus.o_Burst_Len  = 3'd6;

  assign w_trigger  = (r_period == PERIOD_LAST);
  assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

  // The sixth byte is taken straight from the bus so outputs update one cycle after it.
  assign w_heading = {r_shadow[1], r_shadow[0]};
  assign w_roll    = {r_shadow[3], r_shadow[2]};
  assign w_pitch   = {io_Bus.i_Byte_Data, r_shadow[4]};

`ifdef IMU_ANGLE_CLAMP_EN
  function automatic logic [15:0] f_sat(input logic signed [15:0] v, input logic signed [15:0] lim);
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    return v;
  endfunction

  assign w_roll_out  = f_sat(w_roll, 16'sd2880);
  assign w_pitch_out = f_sat(w_pitch, 16'sd1440);
`else
  assign w_roll_out  = w_roll;
  assign w_pitch_out = w_pitch;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state       <= S_IDLE;
      r_period      <= '0;
      r_timeout     <= '0;
      r_fail        <= '0;
      r_idx         <= '0;
      r_burst_req   <= 1'b0;
      o_Heading_Raw <= '0;
      o_Roll_Raw    <= '0;
      o_Pitch_Raw   <= '0;
      o_Valid       <= 1'b0;
      o_Stale       <= 1'b1;
      o_Overrun     <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_Valid  <= 1'b0;
      r_period <= w_trigger ? '0 : r_period + 1'b1;
      if (w_trigger && r_state != S_IDLE)
        o_Overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state     <= S_REQ;
            r_burst_req <= 1'b1;
            r_timeout   <= TIMEOUT_LAST;
            o_Busy      <= 1'b1;
          end
        end

        S_REQ: begin
          if (io_Bus.i_Bus_Err) begin
            r_state     <= S_ERR;
            r_burst_req <= 1'b0;
          end else if (io_Bus.i_Burst_Ack) begin
            r_state     <= S_RECV;
            r_burst_req <= 1'b0;
            r_idx       <= '0;
            r_timeout   <= TIMEOUT_LAST;
          end else if (r_timeout == '0) begin
            r_state     <= S_ERR;
            r_burst_req <= 1'b0;
          end else begin
            r_timeout <= r_timeout - 1'b1;
          end
        end

        S_RECV: begin
          // An error in the same cycle as a byte discards that byte.
          if (io_Bus.i_Bus_Err) begin
            r_state <= S_ERR;
          end else if (io_Bus.i_Byte_Valid) begin
            r_shadow[r_idx] <= io_Bus.i_Byte_Data;
            r_idx           <= r_idx + 3'd1;
            r_timeout       <= TIMEOUT_LAST;
            if (r_idx == 3'd5) begin
              r_state       <= S_COMMIT;
              o_Heading_Raw <= w_heading;
              o_Roll_Raw    <= w_roll_out;
              o_Pitch_Raw   <= w_pitch_out;
              o_Valid       <= 1'b1;
              r_fail        <= '0;
              o_Stale       <= 1'b0;
            end
          end else if (r_timeout == '0) begin
            r_state <= S_ERR;
          end else begin
            r_timeout <= r_timeout - 1'b1;
          end
        end

        S_COMMIT: begin
          r_state <= S_IDLE;
          o_Busy  <= 1'b0;
        end

        S_ERR: begin
          r_fail <= w_fail_inc;
          if (w_fail_inc >= FAIL_MAX)
            o_Stale <= 1'b1;
          r_state <= S_IDLE;
          o_Busy  <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          r_burst_req <= 1'b0;
          o_Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_euler_sampler.sv
// Directed bench for imu_euler_sampler with shortened period and timeout.
module tb_imu_euler_sampler;
  localparam int PERIOD  = 200;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] heading, roll, pitch;
  logic        valid, stale, overrun, busy;
  int          errors = 0;
  int          checks = 0;

  imu_euler_sampler_if bus ();

  imu_euler_sampler #(
    .SAMPLE_PERIOD (PERIOD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .BASE_ADDR     (8'h1A),
    .STALE_LIMIT   (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .io_Bus       (bus.master),
    .o_Heading_Raw(heading),
    .o_Roll_Raw   (roll),
    .o_Pitch_Raw  (pitch),
    .o_Valid      (valid),
    .o_Stale      (stale),
    .o_Overrun    (overrun),
    .o_Busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 1; i <= 2 * PERIOD; i++) begin
      step();
      if (bus.o_Burst_Req) begin
        n = i;
        break;
      end
    end
    check("req_seen", {15'd0, bus.o_Burst_Req}, 16'd1);
  endtask

  task automatic do_ack();
    bus.i_Burst_Ack = 1'b1;
    step();
    bus.i_Burst_Ack = 1'b0;
    check("req_dropped", {15'd0, bus.o_Burst_Req}, 16'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_Byte_Valid = 1'b1;
    bus.i_Byte_Data  = b;
    step();
    bus.i_Byte_Valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] b0, b1, b2, b3, b4, b5,
                            input logic [15:0] eh, er, ep, input string tag);
    logic [7:0] bytes [0:5];
    bytes = '{b0, b1, b2, b3, b4, b5};
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      check({tag, "_no_early_valid"}, {15'd0, valid}, 16'd0);
    end
    send_byte(bytes[5]);
    check({tag, "_valid"}, {15'd0, valid}, 16'd1);
    check({tag, "_heading"}, heading, eh);
    check({tag, "_roll"}, roll, er);
    check({tag, "_pitch"}, pitch, ep);
    check({tag, "_stale"}, {15'd0, stale}, 16'd0);
    step();
    check({tag, "_valid_pulse"}, {15'd0, valid}, 16'd0);
    step();
    check({tag, "_idle"}, {15'd0, busy}, 16'd0);
    $display("burst %s: H=%h R=%h P=%h stale=%0b overrun=%0b", tag, heading, roll, pitch, stale, overrun);
  endtask

  initial begin
    int n;
    int vcount;
    logic [15:0] exp_r, exp_p;
    bus.i_Burst_Ack  = 1'b0;
    bus.i_Byte_Valid = 1'b0;
    bus.i_Byte_Data  = 8'h00;
    bus.i_Bus_Err    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_heading", heading, 16'h0000);
    check("rst_roll", roll, 16'h0000);
    check("rst_pitch", pitch, 16'h0000);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_stale", {15'd0, stale}, 16'd1);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_req", {15'd0, bus.o_Burst_Req}, 16'd0);
    rst = 1'b0;
    $display("reset released");

    // First trigger after exactly PERIOD clocks
    wait_req(n);
    check("first_trigger_cycles", 16'(n), 16'(PERIOD));
    check("req_addr", {8'd0, bus.o_Burst_Addr}, 16'h001A);
    check("req_len", {13'd0, bus.o_Burst_Len}, 16'd6);
    check("req_stale", {15'd0, stale}, 16'd1);
    check("req_busy", {15'd0, busy}, 16'd1);
    check("req_roll", roll, 16'h0000);
    do_ack();
    send_burst(8'h10, 8'h00, 8'hA0, 8'h00, 8'h60, 8'hFF, 16'h0010, 16'h00A0, 16'hFF60, "good1");

    // Failure 1: bus error after 3 bytes, coinciding with a byte
    wait_req(n);
    do_ack();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    bus.i_Bus_Err    = 1'b1;
    bus.i_Byte_Valid = 1'b1;
    bus.i_Byte_Data  = 8'h55;
    step();
    bus.i_Bus_Err    = 1'b0;
    bus.i_Byte_Valid = 1'b0;
    check("err1_valid", {15'd0, valid}, 16'd0);
    step();
    check("err1_busy", {15'd0, busy}, 16'd0);
    check("err1_stale", {15'd0, stale}, 16'd0);
    check("err1_heading", heading, 16'h0010);
    check("err1_roll", roll, 16'h00A0);
    check("err1_pitch", pitch, 16'hFF60);
    $display("burst err1: stale=%0b", stale);

    // Failure 2: bus error while still requesting
    wait_req(n);
    bus.i_Bus_Err = 1'b1;
    step();
    bus.i_Bus_Err = 1'b0;
    check("err2_req_dropped", {15'd0, bus.o_Burst_Req}, 16'd0);
    step();
    check("err2_busy", {15'd0, busy}, 16'd0);
    check("err2_stale", {15'd0, stale}, 16'd0);
    $display("burst err2: stale=%0b", stale);

    // Failure 3: two bytes then silence until timeout
    wait_req(n);
    do_ack();
    send_byte(8'h77);
    send_byte(8'h88);
    vcount = 0;
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      step();
      if (valid) vcount++;
      if (i == TIMEOUT - 1) check("tmo_still_busy", {15'd0, busy}, 16'd1);
    end
    check("tmo_no_valid", 16'(vcount), 16'd0);
    check("tmo_busy", {15'd0, busy}, 16'd0);
    check("tmo_stale", {15'd0, stale}, 16'd1);
    check("tmo_heading", heading, 16'h0010);
    check("tmo_roll", roll, 16'h00A0);
    check("tmo_pitch", pitch, 16'hFF60);
    $display("burst timeout: stale=%0b", stale);

    // Good burst restarts at byte 0 and clears staleness
    wait_req(n);
    do_ack();
    send_burst(8'h34, 8'h12, 8'hF0, 8'hFF, 8'h20, 8'h03, 16'h1234, 16'hFFF0, 16'h0320, "good2");
    check("good2_overrun", {15'd0, overrun}, 16'd0);

    // Slow burst spanning a trigger -> overrun; also the clamp vectors
`ifdef IMU_ANGLE_CLAMP_EN
    exp_r = 16'h0B40;
    exp_p = 16'hFA60;
`else
    exp_r = 16'h1000;
    exp_p = 16'hF000;
`endif
    wait_req(n);
    do_ack();
    begin
      logic [7:0] slow [0:5];
      slow = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'hF0};
      for (int i = 0; i < 6; i++) begin
        repeat (40) step();
        send_byte(slow[i]);
      end
    end
    check("slow_valid", {15'd0, valid}, 16'd1);
    check("slow_heading", heading, 16'h0000);
    check("slow_roll", roll, exp_r);
    check("slow_pitch", pitch, exp_p);
    check("slow_overrun", {15'd0, overrun}, 16'd1);
    $display("burst slow: R=%h P=%h overrun=%0b", roll, pitch, overrun);
    step();

    // Overrun stays sticky across a later good burst
    wait_req(n);
    do_ack();
    send_burst(8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 16'h0001, 16'h0002, 16'h0003, "good3");
    check("good3_overrun", {15'd0, overrun}, 16'd1);

    // Reset clears everything again
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_overrun", {15'd0, overrun}, 16'd0);
    check("rst2_stale", {15'd0, stale}, 16'd1);
    check("rst2_roll", roll, 16'h0000);
    check("rst2_busy", {15'd0, busy}, 16'd0);
    $display("second reset: overrun=%0b stale=%0b", overrun, stale);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
